// File: rtl/parking_pkg.sv
`default_nettype none
// ============================================================================
// Module      : parking_pkg
// Description : Shared definitions for the parking subsystem.
//               - Entry and exit FSM state encodings.
//               - Active-low 7-segment hex table, {g,f,e,d,c,b,a} ordering.
//               - DASH glyph shown when the value cannot fit a hex digit.
// Revision    : 1.0 - initial release
// ============================================================================
package parking_pkg;

  // Entry lane FSM
  localparam logic [1:0] E_IDLE = 2'd0;
  localparam logic [1:0] E_PW   = 2'd1;
  localparam logic [1:0] E_OPEN = 2'd2;
  localparam logic [1:0] E_LOCK = 2'd3;

  // Exit lane FSM
  localparam logic [0:0] X_IDLE = 1'b0;
  localparam logic [0:0] X_OPEN = 1'b1;

  // Only segment g lit (active-low)
  localparam logic [6:0] DASH = 7'b0111111;

  // Active-low hex glyphs, bit 0 = segment a
  function automatic logic [6:0] seg7_hex(input logic [3:0] value);
    logic [6:0] seg;
    case (value)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/parking_lot_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : parking_lot_ctrl_if
// Description : Sensor, keypad and status bundle of the parking controller.
//               master : environment side (drives sensors and keypad)
//               slave  : controller side (drives gates, counters, display)
//               Signals: entrance_sensor, exit_sensor, pw_data[PW_W],
//               pw_valid, entrance_gate, exit_gate, occupancy[OCC_W],
//               lot_full, pw_error, lockout, display[7]
// Revision    : 1.0 - initial release
// ============================================================================
interface parking_lot_ctrl_if #(
  parameter int PW_W     = 4,
  parameter int CAPACITY = 8
);
  localparam int OCC_W = $clog2(CAPACITY + 1);

  logic             entrance_sensor;
  logic             exit_sensor;
  logic [PW_W-1:0]  pw_data;
  logic             pw_valid;
  logic             entrance_gate;
  logic             exit_gate;
  logic [OCC_W-1:0] occupancy;
  logic             lot_full;
  logic             pw_error;
  logic             lockout;
  logic [6:0]       display;

  modport master (
    output entrance_sensor, exit_sensor, pw_data, pw_valid,
    input  entrance_gate, exit_gate, occupancy, lot_full, pw_error,
           lockout, display
  );

  modport slave (
    input  entrance_sensor, exit_sensor, pw_data, pw_valid,
    output entrance_gate, exit_gate, occupancy, lot_full, pw_error,
           lockout, display
  );

endinterface
`default_nettype wire

// File: rtl/seg7_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg7_decoder
// Description : 4-bit value to active-low 7-segment glyph {g,f,e,d,c,b,a}.
//               i_value    : hex digit to show
//               i_overflow : value exceeds one digit, show a dash instead
//               o_seg      : active-low segment drive
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_decoder
  import parking_pkg::*;
(
  input  wire logic [3:0] i_value,
  input  wire logic       i_overflow,
  output logic      [6:0] o_seg
);

  assign o_seg = i_overflow ? DASH : seg7_hex(i_value);

endmodule
`default_nettype wire

// File: rtl/parking_lot_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : parking_lot_ctrl
// Description : Parking lot controller: password-guarded entrance lane, free
//               exit lane, occupancy counter and free-slot 7-seg display.
//               clock, reset (async, active-high) plain ports; all lane and
//               status signals travel on bus (parking_lot_ctrl_if.slave).
//               Optional macro PARKING_LOCKOUT_EN: after MAX_TRIES wrong
//               codes the entrance is locked for LOCKOUT_CYCLES cycles.
//               Without it retries are unlimited and lockout is held at 0.
// Revision    : 1.0 - initial release
// ============================================================================
module parking_lot_ctrl
  import parking_pkg::*;
#(
  parameter int              CAPACITY       = 8,
  parameter int              PW_W           = 4,
  parameter logic [PW_W-1:0] PASSWORD       = 4'b1101,
  parameter int              TIMEOUT        = 10000,
  parameter int              GATE_HOLD      = 500,
  parameter int              MAX_TRIES      = 3,
  parameter int              LOCKOUT_CYCLES = 50000
) (
  input  wire logic          clock,
  input  wire logic          reset,
  parking_lot_ctrl_if.slave  bus
);

  localparam int OCC_W = $clog2(CAPACITY + 1);
  // The entry timer spans every interval and count the entry lane can hold,
  // so its width is the same whether or not lockout is built in.
  localparam int TMR_MAX = max2(max2(TIMEOUT, GATE_HOLD),
                                max2(LOCKOUT_CYCLES, MAX_TRIES));
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int XTMR_W  = $clog2(GATE_HOLD + 1);

  logic [1:0]        r_e_state;
  logic [1:0]        w_e_next;
  logic [TMR_W-1:0]  r_e_tmr;
  logic [0:0]        r_x_state;
  logic [0:0]        w_x_next;
  logic [XTMR_W-1:0] r_x_tmr;

  logic              r_ent_q;
  logic              r_ext_q;
  logic              w_ent_fall;
  logic              w_ext_fall;

  logic [OCC_W-1:0]  r_occ;
  logic [OCC_W-1:0]  w_occ_next;
  logic              w_inc;
  logic              w_dec;

  logic              w_pw_match;
  logic              w_pw_err;

  logic              r_ent_gate;
  logic              r_ext_gate;
  logic              r_lot_full;
  logic              r_pw_err;

  logic [7:0]        w_free;

  // --------------------------------------------------------------------------
  // Sensor edge detection
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ent_q <= 1'b0;
      r_ext_q <= 1'b0;
    end else begin
      r_ent_q <= bus.entrance_sensor;
      r_ext_q <= bus.exit_sensor;
    end
  end

  assign w_ent_fall = r_ent_q & ~bus.entrance_sensor;
  assign w_ext_fall = r_ext_q & ~bus.exit_sensor;

  assign w_pw_match = (bus.pw_data == PASSWORD);
  assign w_pw_err   = (r_e_state == E_PW) && bus.pw_valid && !w_pw_match;

  // --------------------------------------------------------------------------
  // Wrong-try counter
  // --------------------------------------------------------------------------
`ifdef PARKING_LOCKOUT_EN
  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  logic [TRY_W-1:0] r_tries;
  logic             r_lockout;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tries <= '0;
    end else if ((r_e_state == E_PW) && bus.pw_valid && w_pw_match) begin
      r_tries <= '0;
    end else if ((r_e_state == E_LOCK) && (w_e_next == E_IDLE)) begin
      r_tries <= '0;
    end else if (w_pw_err) begin
      r_tries <= r_tries + TRY_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_lockout <= 1'b0;
    end else begin
      r_lockout <= (w_e_next == E_LOCK);
    end
  end

  assign bus.lockout = r_lockout;
`else
  assign bus.lockout = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Entry FSM
  // --------------------------------------------------------------------------
  always_comb begin
    w_e_next = r_e_state;
    w_inc    = 1'b0;
    case (r_e_state)
      E_IDLE: begin
        if (bus.entrance_sensor && !r_lot_full) begin
          w_e_next = E_PW;
        end
      end
      E_PW: begin
        // A correct code on the final timeout cycle still opens the gate.
        if (bus.pw_valid && w_pw_match) begin
          w_e_next = E_OPEN;
`ifdef PARKING_LOCKOUT_EN
        end else if (bus.pw_valid && (r_tries == TRY_W'(MAX_TRIES - 1))) begin
          w_e_next = E_LOCK;
`endif
        end else if (r_e_tmr == TMR_W'(TIMEOUT - 1)) begin
          w_e_next = E_IDLE;
        end
      end
      E_OPEN: begin
        if (w_ent_fall) begin
          w_inc    = 1'b1;
          w_e_next = E_IDLE;
        end else if (r_e_tmr == TMR_W'(GATE_HOLD - 1)) begin
          w_e_next = E_IDLE;
        end
      end
`ifdef PARKING_LOCKOUT_EN
      E_LOCK: begin
        if (r_e_tmr == TMR_W'(LOCKOUT_CYCLES - 1)) begin
          w_e_next = E_IDLE;
        end
      end
`endif
      default: w_e_next = E_IDLE;
    endcase
  end

  // Timer restarts at zero on every state change and rests in E_IDLE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_e_state <= E_IDLE;
      r_e_tmr   <= '0;
    end else begin
      r_e_state <= w_e_next;
      if ((w_e_next != r_e_state) || (r_e_state == E_IDLE)) begin
        r_e_tmr <= '0;
      end else begin
        r_e_tmr <= r_e_tmr + TMR_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Exit FSM
  // --------------------------------------------------------------------------
  always_comb begin
    w_x_next = r_x_state;
    w_dec    = 1'b0;
    case (r_x_state)
      X_IDLE: begin
        if (bus.exit_sensor && (r_occ != '0)) begin
          w_x_next = X_OPEN;
        end
      end
      X_OPEN: begin
        if (w_ext_fall) begin
          w_dec    = 1'b1;
          w_x_next = X_IDLE;
        end else if (r_x_tmr == XTMR_W'(GATE_HOLD - 1)) begin
          w_x_next = X_IDLE;
        end
      end
      default: w_x_next = X_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_x_state <= X_IDLE;
      r_x_tmr   <= '0;
    end else begin
      r_x_state <= w_x_next;
      if ((w_x_next != r_x_state) || (r_x_state == X_IDLE)) begin
        r_x_tmr <= '0;
      end else begin
        r_x_tmr <= r_x_tmr + XTMR_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Occupancy: simultaneous in/out cancels, saturates at both ends
  // --------------------------------------------------------------------------
  always_comb begin
    w_occ_next = r_occ;
    if (w_inc && !w_dec && (r_occ != OCC_W'(CAPACITY))) begin
      w_occ_next = r_occ + OCC_W'(1);
    end else if (w_dec && !w_inc && (r_occ != '0)) begin
      w_occ_next = r_occ - OCC_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Registered outputs, loaded from next-state values so they line up with
  // the state they describe
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_occ      <= '0;
      r_lot_full <= 1'b0;
      r_ent_gate <= 1'b0;
      r_ext_gate <= 1'b0;
      r_pw_err   <= 1'b0;
    end else begin
      r_occ      <= w_occ_next;
      r_lot_full <= (w_occ_next == OCC_W'(CAPACITY));
      r_ent_gate <= (w_e_next == E_OPEN);
      r_ext_gate <= (w_x_next == X_OPEN);
      r_pw_err   <= w_pw_err;
    end
  end

  assign bus.occupancy     = r_occ;
  assign bus.lot_full      = r_lot_full;
  assign bus.entrance_gate = r_ent_gate;
  assign bus.exit_gate     = r_ext_gate;
  assign bus.pw_error      = r_pw_err;

  // --------------------------------------------------------------------------
  // Free-slot display
  // --------------------------------------------------------------------------
  assign w_free = 8'(CAPACITY) - 8'(r_occ);

  seg7_decoder u_seg7 (
    .i_value    (w_free[3:0]),
    .i_overflow (|w_free[7:4]),
    .o_seg      (bus.display)
  );

endmodule
`default_nettype wire

// File: tb/tb_parking_lot_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_parking_lot_ctrl
// Description : Self-checking bench for parking_lot_ctrl. Directed lane
//               scenarios followed by randomized sensor/keypad traffic, all
//               compared cycle by cycle against a behavioural lot model.
//               Honours PARKING_LOCKOUT_EN when the design is built with it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parking_lot_ctrl;

  localparam int         CAP       = 2;
  localparam int         PW_W      = 4;
  localparam int         TIMEOUT   = 20;
  localparam int         GATE_HOLD = 10;
  localparam int         MAX_TRIES = 3;
  localparam int         LOCK_CYC  = 30;
  localparam logic [3:0] PASS      = 4'b1101;
`ifdef PARKING_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  // Active-high hex glyphs, bit 0 = segment a
  localparam logic [6:0] SEG_HI [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  parking_lot_ctrl_if #(.PW_W(PW_W), .CAPACITY(CAP)) bus ();

  parking_lot_ctrl #(
    .CAPACITY       (CAP),
    .PW_W           (PW_W),
    .PASSWORD       (PASS),
    .TIMEOUT        (TIMEOUT),
    .GATE_HOLD      (GATE_HOLD),
    .MAX_TRIES      (MAX_TRIES),
    .LOCKOUT_CYCLES (LOCK_CYC)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [6:0] exp_display(input int free_slots);
    if (free_slots > 15) return 7'b0111111;
    return ~SEG_HI[free_slots];
  endfunction

  // --------------------------------------------------------------------------
  // Lot model: what a car/keypad observer expects after each clock
  // --------------------------------------------------------------------------
  int m_occ;
  int m_ent;        // 0 waiting for car, 1 awaiting code, 2 gate up, 3 locked
  int m_ent_left;   // cycles remaining in the current entrance phase
  bit m_ex_open;
  int m_ex_left;
  bit m_prev_e, m_prev_x;
  int m_tries;
  bit m_perr;

  task automatic model_reset();
    m_occ = 0; m_ent = 0; m_ent_left = 0; m_ex_open = 0; m_ex_left = 0;
    m_prev_e = 0; m_prev_x = 0; m_tries = 0; m_perr = 0;
  endtask

  task automatic model_step(input bit es, input bit xs, input logic [3:0] pd,
                            input bit pv);
    bit fe, fx, match;
    int inc, dec;
    fe = m_prev_e && !es;
    fx = m_prev_x && !xs;
    match = pv && (pd == PASS);
    inc = 0; dec = 0; m_perr = 0;
    case (m_ent)
      0: if (es && m_occ < CAP) begin m_ent = 1; m_ent_left = TIMEOUT; end
      1: begin
        if (pv && !match) m_perr = 1;
        if (match) begin
          m_ent = 2; m_ent_left = GATE_HOLD; m_tries = 0;
        end else begin
          if (pv) m_tries++;
          if (LOCK_EN && pv && m_tries >= MAX_TRIES) begin
            m_ent = 3; m_ent_left = LOCK_CYC;
          end else if (m_ent_left == 1) m_ent = 0;
          else m_ent_left--;
        end
      end
      2: begin
        if (fe) begin inc = 1; m_ent = 0; end
        else if (m_ent_left == 1) m_ent = 0;
        else m_ent_left--;
      end
      default: begin
        if (m_ent_left == 1) begin m_ent = 0; m_tries = 0; end
        else m_ent_left--;
      end
    endcase
    if (!m_ex_open) begin
      if (xs && m_occ > 0) begin m_ex_open = 1; m_ex_left = GATE_HOLD; end
    end else begin
      if (fx) begin dec = 1; m_ex_open = 0; end
      else if (m_ex_left == 1) m_ex_open = 0;
      else m_ex_left--;
    end
    if (inc == 1 && dec == 0 && m_occ < CAP) m_occ++;
    if (dec == 1 && inc == 0 && m_occ > 0) m_occ--;
    m_prev_e = es;
    m_prev_x = xs;
  endtask

  task automatic check_outputs();
    check_eq("entrance_gate", bus.entrance_gate, (m_ent == 2));
    check_eq("exit_gate", bus.exit_gate, m_ex_open);
    check_eq("occupancy", bus.occupancy, m_occ);
    check_eq("lot_full", bus.lot_full, (m_occ == CAP));
    check_eq("pw_error", bus.pw_error, m_perr);
    check_eq("lockout", bus.lockout, (m_ent == 3));
    check_eq("display", bus.display, exp_display(CAP - m_occ));
  endtask

  task automatic tick(input bit es, input bit xs, input logic [3:0] pd,
                      input bit pv);
    @(negedge clock);
    bus.entrance_sensor = es;
    bus.exit_sensor     = xs;
    bus.pw_data         = pd;
    bus.pw_valid        = pv;
    @(posedge clock);
    model_step(es, xs, pd, pv);
    #1 check_outputs();
  endtask

  // Reset is raised between edges so only the asynchronous path can act.
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    bus.entrance_sensor = 1'b0;
    bus.exit_sensor     = 1'b0;
    bus.pw_valid        = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic enter_car();
    tick(1, 0, 4'h0, 0);
    repeat (3) tick(1, 0, 4'h0, 0);
    tick(1, 0, PASS, 1);
    check_eq("gate_after_code", bus.entrance_gate, 1);
    tick(0, 0, 4'h0, 0);
  endtask

  task automatic exit_car();
    tick(0, 1, 4'h0, 0);
    tick(0, 1, 4'h0, 0);
    tick(0, 0, 4'h0, 0);
  endtask

  initial begin
    int lock_cnt, err_cnt;
    bit es, xs;
    bus.entrance_sensor = 1'b0;
    bus.exit_sensor     = 1'b0;
    bus.pw_data         = '0;
    bus.pw_valid        = 1'b0;
    model_reset();

    do_reset();
    check_eq("rst_display", bus.display, 7'b0100100);

    // Single entry
    enter_car();
    check_eq("t1_occ", bus.occupancy, 1);
    check_eq("t1_display", bus.display, 7'b1111001);

    // Fill the lot, then a third car is refused
    enter_car();
    check_eq("t2_full", bus.lot_full, 1);
    check_eq("t2_display", bus.display, 7'b1000000);
    repeat (3) tick(1, 0, 4'h0, 0);
    tick(1, 0, PASS, 1);
    check_eq("t2_gate_refused", bus.entrance_gate, 0);
    tick(0, 0, 4'h0, 0);
    exit_car();
    check_eq("t2_exit_occ", bus.occupancy, 1);

    // Entry and exit complete on the same cycle
    tick(1, 0, 4'h0, 0);
    tick(1, 0, PASS, 1);
    tick(1, 1, 4'h0, 0);
    check_eq("t4_both_open", {bus.entrance_gate, bus.exit_gate}, 2'b11);
    tick(0, 0, 4'h0, 0);
    check_eq("t4_occ", bus.occupancy, 1);

    // Code entry times out; a late code does nothing
    tick(1, 0, 4'h0, 0);
    repeat (TIMEOUT) tick(0, 0, 4'h0, 0);
    tick(0, 0, PASS, 1);
    check_eq("t3_late_code_gate", bus.entrance_gate, 0);
    check_eq("t3_occ", bus.occupancy, 1);

    // Correct code on the final allowed cycle still opens
    tick(1, 0, 4'h0, 0);
    repeat (TIMEOUT - 1) tick(0, 0, 4'h0, 0);
    tick(0, 0, PASS, 1);
    check_eq("t3_edge_code_gate", bus.entrance_gate, 1);
    tick(1, 0, 4'h0, 0);
    tick(0, 0, 4'h0, 0);
    check_eq("t3_edge_occ", bus.occupancy, 2);

    // Reset while a gate is open and the lot is full
    tick(0, 1, 4'h0, 0);
    check_eq("t6_pre_gate", bus.exit_gate, 1);
    check_eq("t6_pre_occ", bus.occupancy, 2);
    do_reset();

    // Wrong codes: lockout when built in, endless retries otherwise
    lock_cnt = 0;
    err_cnt  = 0;
    tick(1, 0, 4'h0, 0);
    for (int j = 0; j < 50; j++) begin
      if (j == 0 || j == 2 || j == 4) tick(1, 0, 4'b0000, 1);
      else if (j == 10)               tick(1, 0, PASS, 1);
      else                            tick(1, 0, 4'h0, 0);
      lock_cnt += int'(bus.lockout);
      err_cnt  += int'(bus.pw_error);
    end
    check_eq("t5_pw_errors", err_cnt, 3);
    check_eq("t5_lockout_cycles", lock_cnt, LOCK_EN ? LOCK_CYC : 0);
    tick(0, 0, 4'h0, 0);
    do_reset();

    // Randomized traffic
    es = 0;
    xs = 0;
    for (int i = 0; i < 2000; i++) begin
      logic [3:0] pd;
      bit pv;
      if ($urandom_range(7) == 0) es = ~es;
      if ($urandom_range(7) == 0) xs = ~xs;
      pv = ($urandom_range(3) == 0);
      pd = ($urandom_range(2) == 0) ? PASS : 4'($urandom);
      if ($urandom_range(499) == 0) begin
        do_reset();
        es = 0;
        xs = 0;
      end else begin
        tick(es, xs, pd, pv);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
